sdp_x_mul_core_triosy_multi_obj: RTL

- Multi-channel, parametrised successor of the single-channel triosy sync object used by the SDP X mul core.
- Issues per-channel "output valid" (lz) strobes to the triosy IO pads, with optional pulse stretching.
- Tracks per-channel completion that arrives while the core is stalled, until the core consumes it.
- Aggregates channel status into one all-complete flag and a sticky protocol-error flag for the core FSM.

---
 rtl/sdp_x_triosy_pkg.sv | 19 +
 rtl/sdp_x_triosy_chan.sv | 53 +++++
 rtl/sdp_x_mul_core_triosy_multi_obj.sv | 66 ++++++
 3 files changed

// File: rtl/sdp_x_triosy_pkg.sv
// Shared types and helpers for the SDP X mul core multi-channel triosy object.
package sdp_x_triosy_pkg;

  localparam int LZ_CNT_W = 4;
  localparam int MAX_CH   = 16;

  typedef struct packed {
    logic                bcwt;
    logic [LZ_CNT_W-1:0] lz_cnt;
  } chan_status_t;

  // Channels outside the mask read as complete; unused upper bits are zero in
  // both vectors, so they drop out of the reduction.
  function automatic logic masked_and(input logic [MAX_CH-1:0] v,
                                      input logic [MAX_CH-1:0] m);
    return &(v | ~m);
  endfunction

endpackage

// File: rtl/sdp_x_triosy_chan.sv
// One triosy channel: held completion, lz stretch down-counter, and the
// optional lz event counter (SDP_TRIOSY_EVT_CNT_EN).
module sdp_x_triosy_chan
  import sdp_x_triosy_pkg::*;
#(
  parameter int LZ_STRETCH = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             biwt,
  input  logic             bdwt,
`ifdef SDP_TRIOSY_EVT_CNT_EN
  output logic [CNT_W-1:0] evt_cnt,
`endif
  output logic             lz,
  output logic             bawt
);

  // A load value of zero collapses the stretch counter for the legacy strobe.
  localparam logic [LZ_CNT_W-1:0] LZ_LOAD = LZ_CNT_W'(LZ_STRETCH - 1);

  chan_status_t st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= '0;
    end else begin
      st.bcwt <= (st.bcwt | biwt) & ~bdwt;
      if (biwt)
        st.lz_cnt <= LZ_LOAD;
      else if (st.lz_cnt != '0)
        st.lz_cnt <= st.lz_cnt - 1'b1;
    end
  end

  assign lz   = ~rst & (biwt | (st.lz_cnt != '0));
  assign bawt = ~rst & (biwt | st.bcwt);

`ifdef SDP_TRIOSY_EVT_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (biwt && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

  assign evt_cnt = rst ? '0 : cnt;
`endif

endmodule

// File: rtl/sdp_x_mul_core_triosy_multi_obj.sv
// Multi-channel triosy sync object: per-channel lz/bawt, masked all-complete and
// sticky protocol error. Optional per-channel counters via SDP_TRIOSY_EVT_CNT_EN.
module sdp_x_mul_core_triosy_multi_obj
  import sdp_x_triosy_pkg::*;
#(
  parameter int             NCH        = 4,
  parameter int             LZ_STRETCH = 1,
  parameter logic [NCH-1:0] CH_MASK    = {NCH{1'b1}},
  parameter int             CNT_W      = 8
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rst,
  input  logic                 core_wen,
  input  logic                 core_wten,
  input  logic [NCH-1:0]       obj_iswt0,
  input  logic [NCH-1:0]       obj_oswt,
`ifdef SDP_TRIOSY_EVT_CNT_EN
  output logic [NCH*CNT_W-1:0] evt_cnt,
`endif
  output logic [NCH-1:0]       triosy_lz,
  output logic [NCH-1:0]       obj_bawt,
  output logic                 all_bawt,
  output logic                 proto_err
);

  logic [NCH-1:0] biwt;
  logic [NCH-1:0] bdwt;
  logic           err_q;
  logic           err_set;

  assign biwt = {NCH{~core_wten}} & obj_iswt0;
  assign bdwt = obj_oswt & {NCH{core_wen}};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    sdp_x_triosy_chan #(
      .LZ_STRETCH (LZ_STRETCH),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk     (nvdla_core_clk),
      .rst     (nvdla_core_rst),
      .biwt    (biwt[i]),
      .bdwt    (bdwt[i]),
`ifdef SDP_TRIOSY_EVT_CNT_EN
      .evt_cnt (evt_cnt[i*CNT_W +: CNT_W]),
`endif
      .lz      (triosy_lz[i]),
      .bawt    (obj_bawt[i])
    );
  end

  assign all_bawt = ~nvdla_core_rst
                  & masked_and(MAX_CH'(obj_bawt), MAX_CH'(CH_MASK));

  // Consuming with nothing available, or being told to advance and stall at once.
  assign err_set = (|(bdwt & ~obj_bawt)) | (core_wen & core_wten);

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst)
      err_q <= 1'b0;
    else if (err_set)
      err_q <= 1'b1;
  end

  assign proto_err = ~nvdla_core_rst & err_q;

endmodule
